result_scanner: RTL and testbench

Post-sort readout stage for the MIPS single-cycle sorting design. After the CPU signals sort completion, the block walks the 10-word data memory in address order and presents each word to the seven-segment display driver. It drives the one-hot position LEDs in step with the displayed word. On the first pass it checks that the sequence is non-decreasing (unsigned) and reports pass or fail.

---
 rtl/result_scanner.sv | 123 ++++++++++++
 tb/tb_result_scanner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_scanner.sv
// result_scanner: post-sort readout of data memory to the display driver.
// Walks the words in address order and checks the first pass is non-decreasing.
module result_scanner #(
    parameter int N_WORDS = 10,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int DWELL   = 50_000_000
) (
    input  logic               Clk,
    input  logic               Clr,
    input  logic               start,
    input  logic               auto_mode,
    input  logic               step,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [DATA_W-1:0]  mem_rd_data,
    output logic [DATA_W-1:0]  disp_data,
    output logic [N_WORDS-1:0] disp_led,
    output logic               disp_valid,
    output logic               busy,
    output logic               done,
    output logic               order_err
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);
    localparam logic [N_WORDS-1:0] LED_ADDR0 = {1'b1, {(N_WORDS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, READ, LATCH, SHOW} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] prev;
    logic              first_pass;
    logic [CNT_W-1:0]  cnt;
    logic              advance;
    logic              stop;

    // Leaving SHOW: dwell expired in auto mode, or a step pulse in manual mode.
    assign advance = (state == SHOW) && (auto_mode ? (cnt == LAST_CNT) : step);
    // Dropping start anywhere outside IDLE aborts the scan.
    assign stop    = (state != IDLE) && !start;
    assign mem_rd_addr = idx;

    // State register.
    always_ff @(posedge Clk) begin
        if (Clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection; abort has priority over advance.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = READ;
            READ:  state_nxt = LATCH;
            LATCH: state_nxt = SHOW;
            SHOW:  if (advance) state_nxt = READ;
            default: state_nxt = IDLE;
        endcase
        if (stop) state_nxt = IDLE;
    end

    // Combinational outputs decoded from the state.
    always_comb begin
        mem_rd_en = (state == READ);
        busy      = (state != IDLE);
    end

    // Scan datapath: index, display registers, dwell counter, sticky flags.
    always_ff @(posedge Clk) begin
        if (Clr || stop) begin
            idx        <= '0;
            prev       <= '0;
            first_pass <= 1'b0;
            cnt        <= '0;
            disp_data  <= '0;
            disp_led   <= '0;
            disp_valid <= 1'b0;
            done       <= 1'b0;
            order_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        prev       <= '0;
                        first_pass <= 1'b1;
                        order_err  <= 1'b0;
                    end
                end
                LATCH: begin
                    disp_data  <= mem_rd_data;
                    disp_led   <= LED_ADDR0 >> idx;
                    disp_valid <= 1'b1;
                    if (first_pass && (idx != '0) && (mem_rd_data < prev))
                        order_err <= 1'b1;
                    prev <= mem_rd_data;
                    cnt  <= '0;
                end
                SHOW: begin
                    if (advance) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (first_pass) begin
                                done       <= 1'b1;
                                first_pass <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (auto_mode) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_scanner.sv
// tb_result_scanner: directed and randomized checks of result_scanner
// against a reference model of the scan timeline and ordering rules.
module tb_result_scanner;

    localparam int N     = 10;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DWELL = 4;

    logic          Clk = 1'b0;
    logic          Clr;
    logic          start;
    logic          auto_mode;
    logic          step;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] disp_data;
    logic [N-1:0]  disp_led;
    logic          disp_valid;
    logic          busy;
    logic          done;
    logic          order_err;

    logic [DW-1:0] mem [N];

    int checks   = 0;
    int failures = 0;

    result_scanner #(
        .N_WORDS(N), .ADDR_W(AW), .DATA_W(DW), .DWELL(DWELL)
    ) dut (
        .Clk(Clk), .Clr(Clr), .start(start), .auto_mode(auto_mode),
        .step(step), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .disp_data(disp_data),
        .disp_led(disp_led), .disp_valid(disp_valid), .busy(busy),
        .done(done), .order_err(order_err)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read memory: data valid one cycle after the strobe.
    always_ff @(posedge Clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] led_of(input int k);
        logic [N-1:0] one;
        one = 1;
        return one << (N - 1 - k);
    endfunction

    // Any descent seen so far during the first pass, once word w is on show.
    function automatic logic exp_err(input int w);
        int lim;
        lim = (w >= N) ? N - 1 : w;
        for (int j = 1; j <= lim; j++)
            if (mem[j] < mem[j-1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_done(input int w, input int c);
        return (w >= N) || (w == N - 1 && c >= DWELL);
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".valid"}, 32'(disp_valid), 0);
        chk({tag, ".data"},  32'(disp_data), 0);
        chk({tag, ".led"},   32'(disp_led), 0);
        chk({tag, ".done"},  32'(done), 0);
        chk({tag, ".err"},   32'(order_err), 0);
        chk({tag, ".rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, ".addr"},  32'(mem_rd_addr), 0);
    endtask

    // READ of address 0 then LATCH; called at a negedge.
    task automatic begin_scan(input bit set_start);
        if (set_start) start = 1'b1;
        @(negedge Clk);
        chk("scan0.rd_en", 32'(mem_rd_en), 1);
        chk("scan0.addr", 32'(mem_rd_addr), 0);
        chk("scan0.busy", 32'(busy), 1);
        chk("scan0.valid", 32'(disp_valid), 0);
        @(negedge Clk);
        chk("scan1.valid", 32'(disp_valid), 0);
        chk("scan1.rd_en", 32'(mem_rd_en), 0);
    endtask

    // One auto-mode display window of scan step w (w counts across passes).
    task automatic window(input int w, input int ncyc);
        int k;
        int kn;
        k  = w % N;
        kn = (w + 1) % N;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clk);
            chk("win.data", 32'(disp_data), 32'(mem[k]));
            chk("win.led", 32'(disp_led), 32'(led_of(k)));
            chk("win.valid", 32'(disp_valid), 1);
            chk("win.busy", 32'(busy), 1);
            chk("win.rd_en", 32'(mem_rd_en), 32'(c == DWELL));
            chk("win.addr", 32'(mem_rd_addr), 32'((c >= DWELL) ? kn : k));
            chk("win.err", 32'(order_err), 32'(exp_err(w)));
            chk("win.done", 32'(done), 32'(exp_done(w, c)));
        end
    endtask

    task automatic stop_scan();
        start = 1'b0;
        @(negedge Clk);
        check_idle("stop");
    endtask

    task automatic manual_step(input int from, input int to);
        step = 1'b1;
        @(negedge Clk);
        step = 1'b0;
        chk("man.rd_en", 32'(mem_rd_en), 1);
        chk("man.addr", 32'(mem_rd_addr), 32'(to));
        chk("man.old0", 32'(disp_data), 32'(mem[from]));
        @(negedge Clk);
        chk("man.old1", 32'(disp_data), 32'(mem[from]));
        @(negedge Clk);
        chk("man.new", 32'(disp_data), 32'(mem[to]));
        chk("man.led", 32'(disp_led), 32'(led_of(to)));
    endtask

    task automatic fill_ascending();
        int v;
        v = $urandom_range(0, 1000);
        for (int i = 0; i < N; i++) begin
            mem[i] = 16'(v);
            v += $urandom_range(0, 3);
        end
    endtask

    initial begin
        Clr       = 1'b1;
        start     = 1'b0;
        auto_mode = 1'b1;
        step      = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 16'(i);

        // Reset state
        repeat (2) @(negedge Clk);
        check_idle("reset");
        Clr = 1'b0;
        @(negedge Clk);
        check_idle("idle");

        // Ascending 0..9, auto mode, one full pass plus wrap
        begin_scan(1);
        for (int w = 0; w <= N; w++) window(w, DWELL + 2);
        stop_scan();

        // Descent at address 3, equal pair does not flag
        mem[0] = 3; mem[1] = 5; mem[2] = 5; mem[3] = 2;
        for (int i = 4; i < N; i++) mem[i] = 16'(i + 2);
        begin_scan(1);
        for (int w = 0; w < N + 3; w++) window(w, DWELL + 2);
        stop_scan();

        // Drop start in SHOW of address 4, then restart with flags clear
        begin_scan(1);
        for (int w = 0; w < 4; w++) window(w, DWELL + 2);
        window(4, 1);
        stop_scan();
        begin_scan(1);
        for (int w = 0; w < 5; w++) window(w, DWELL + 2);
        stop_scan();

        // Clr during LATCH of address 3, start held
        fill_ascending();
        begin_scan(1);
        for (int w = 0; w < 2; w++) window(w, DWELL + 2);
        window(2, DWELL + 2);
        Clr = 1'b1;
        @(negedge Clk);
        check_idle("clr");
        Clr = 1'b0;
        begin_scan(0);
        for (int w = 0; w < 2; w++) window(w, DWELL + 2);
        stop_scan();

        // Unsigned compare: FFFF followed by 0
        mem[0] = 16'hFFFF;
        for (int i = 1; i < N; i++) mem[i] = 16'(i - 1);
        begin_scan(1);
        for (int w = 0; w < 2; w++) window(w, DWELL + 2);
        stop_scan();

        // Randomized memories
        for (int r = 0; r < 4; r++) begin
            if (r % 2 == 0) fill_ascending();
            else for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
            begin_scan(1);
            for (int w = 0; w <= N; w++) window(w, DWELL + 2);
            stop_scan();
        end

        // Manual mode
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        auto_mode = 1'b0;
        begin_scan(1);
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            chk("man.hold", 32'(disp_data), 32'(mem[0]));
        end
        manual_step(0, 1);
        manual_step(1, 2);
        manual_step(2, 3);
        // Steps held across READ/LATCH after a valid step are ignored
        step = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("man.ign_latch", 32'(mem_rd_addr), 4);
        @(negedge Clk);
        step = 1'b0;
        chk("man.ign_show", 32'(disp_data), 32'(mem[4]));
        repeat (10) @(negedge Clk);
        chk("man.ign_data", 32'(disp_data), 32'(mem[4]));
        chk("man.ign_addr", 32'(mem_rd_addr), 4);
        // Switch to auto mid-SHOW; dwell count was held at zero
        auto_mode = 1'b1;
        for (int c = 1; c <= DWELL + 1; c++) begin
            @(negedge Clk);
            chk("mode.old", 32'(disp_data), 32'(mem[4]));
        end
        @(negedge Clk);
        chk("mode.new", 32'(disp_data), 32'(mem[5]));
        chk("mode.led", 32'(disp_led), 32'(led_of(5)));
        stop_scan();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
